// File: rtl/calc_pkg.sv
// Shared types for the calculator controller: operator codes, FSM states, default width.
package calc_pkg;

    localparam int CALC_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_NEG  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100
    } op_e;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        SHOW    = 3'd3,
        ERROR   = 3'd4
    } state_e;

    // Binary operators that need a second operand.
    function automatic logic is_arith(input logic [2:0] code);
        return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Sign/magnitude operand register: mag*10+digit with MAX_MAG clamp, sign toggle, direct load.
// One-cycle update; an over-range digit is silently dropped, no backpressure.
module calc_digit_accum #(
    parameter int WIDTH   = 16,
    parameter int MAX_MAG = 32767
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    clear,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_mag,
    input  logic                    load_sign,
    input  logic                    digit_vld,
    input  logic [3:0]              digit,
    input  logic                    neg,
    output logic signed [WIDTH-1:0] value
);

    localparam int EW = WIDTH + 4;

    logic [WIDTH-1:0] mag;
    logic             sign;
    logic [EW-1:0]    grown;

    // Four spare bits keep mag*10+9 from wrapping before the range check.
    assign grown = {4'd0, mag} * EW'(10) + EW'(digit);
    assign value = sign ? -mag : mag;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mag  <= '0;
            sign <= 1'b0;
        end else if (clear) begin
            mag  <= '0;
            sign <= 1'b0;
        end else if (load) begin
            mag  <= load_mag;
            sign <= load_sign;
        end else begin
            if (digit_vld && (grown <= EW'(MAX_MAG)))
                mag <= grown[WIDTH-1:0];
            if (neg)
                sign <= ~sign;
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad-driven calculator FSM with req/ack ALU handshake; CALC_CHAIN_EN lets an operator chain off a result.
// Keys acknowledged combinationally in the accepting cycle; keys are left pending while the ALU request is open.
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH   = CALC_WIDTH,
    parameter int MAX_MAG = 32767
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    key_rdy,
    output logic                    key_rd,
    input  logic [3:0]              keypad_input,
    input  logic [2:0]              operator_input,
    input  logic                    equal_input,
    output logic                    alu_req,
    input  logic                    alu_ack,
    output logic signed [WIDTH-1:0] alu_a,
    output logic signed [WIDTH-1:0] alu_b,
    output logic [2:0]              alu_op,
    input  logic signed [WIDTH-1:0] alu_result,
    input  logic                    alu_ovf,
    output logic signed [WIDTH-1:0] display_value,
    output logic                    err
);

    localparam logic [2:0] ST_ENTER_A = ENTER_A;
    localparam logic [2:0] ST_ENTER_B = ENTER_B;
    localparam logic [2:0] ST_EXEC    = EXEC;
    localparam logic [2:0] ST_SHOW    = SHOW;
    localparam logic [2:0] ST_ERROR   = ERROR;

    logic [2:0]              state;
    logic [2:0]              op_q;
    logic signed [WIDTH-1:0] result_q;
    logic                    key_taken;
    logic                    live;

    logic accept;
    logic k_eq, k_neg, k_arith, k_digit;
    logic chain;

    logic [WIDTH-1:0]        res_bits;
    logic [WIDTH-1:0]        res_mag;
    logic signed [WIDTH-1:0] val_a, val_b;

    logic             clr_a, load_a, dig_a, neg_a, sign_a;
    logic [WIDTH-1:0] mag_a;
    logic             clr_b, dig_b, neg_b;

    // live holds off key acceptance until the first clock after reset, so key_rd stays low in reset.
    assign accept = live && key_rdy && !key_taken && (state != ST_EXEC);
    assign key_rd = accept;

    always_comb begin
        k_eq    = accept && equal_input;
        k_neg   = accept && !equal_input && (operator_input == OP_NEG);
        k_arith = accept && !equal_input && is_arith(operator_input);
        k_digit = accept && !equal_input && (operator_input == OP_NONE) && (keypad_input <= 4'd9);
    end

`ifdef CALC_CHAIN_EN
    assign chain = (state == ST_SHOW) && k_arith;
`else
    assign chain = 1'b0;
`endif

    assign res_bits = result_q;
    assign res_mag  = res_bits[WIDTH-1] ? -res_bits : res_bits;

    always_comb begin
        clr_a  = (state == ST_ERROR) && k_eq;
        load_a = (state == ST_SHOW) && (k_digit || k_neg || chain);
        mag_a  = k_digit ? {{(WIDTH-4){1'b0}}, keypad_input} : res_mag;
        sign_a = k_neg ? ~res_bits[WIDTH-1] : (k_digit ? 1'b0 : res_bits[WIDTH-1]);
        dig_a  = (state == ST_ENTER_A) && k_digit;
        neg_a  = (state == ST_ENTER_A) && k_neg;
        clr_b  = ((state == ST_ENTER_A) && k_arith) || chain || clr_a;
        dig_b  = (state == ST_ENTER_B) && k_digit;
        neg_b  = (state == ST_ENTER_B) && k_neg;
    end

    calc_digit_accum #(.WIDTH(WIDTH), .MAX_MAG(MAX_MAG)) u_acc_a (
        .clk       (clk),
        .nRST      (nRST),
        .clear     (clr_a),
        .load      (load_a),
        .load_mag  (mag_a),
        .load_sign (sign_a),
        .digit_vld (dig_a),
        .digit     (keypad_input),
        .neg       (neg_a),
        .value     (val_a)
    );

    calc_digit_accum #(.WIDTH(WIDTH), .MAX_MAG(MAX_MAG)) u_acc_b (
        .clk       (clk),
        .nRST      (nRST),
        .clear     (clr_b),
        .load      (1'b0),
        .load_mag  ('0),
        .load_sign (1'b0),
        .digit_vld (dig_b),
        .digit     (keypad_input),
        .neg       (neg_b),
        .value     (val_b)
    );

    assign alu_req = (state == ST_EXEC);

    always_comb begin
        display_value = '0;
        case (state)
            ST_ENTER_A:         display_value = val_a;
            ST_ENTER_B, ST_EXEC: display_value = val_b;
            ST_SHOW:            display_value = result_q;
            default:            display_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_ENTER_A;
            op_q      <= OP_NONE;
            result_q  <= '0;
            key_taken <= 1'b0;
            live      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_NONE;
            err       <= 1'b0;
        end else begin
            live <= 1'b1;
            if (!key_rdy)
                key_taken <= 1'b0;
            else if (accept)
                key_taken <= 1'b1;

            case (state)
                ST_ENTER_A: begin
                    if (k_arith) begin
                        op_q  <= operator_input;
                        state <= ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (k_arith) begin
                        op_q <= operator_input;
                    end else if (k_eq) begin
                        alu_a  <= val_a;
                        alu_b  <= val_b;
                        alu_op <= op_q;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (alu_ack) begin
                        result_q <= alu_result;
                        if (alu_ovf) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    if (k_digit || k_neg) begin
                        state <= ST_ENTER_A;
                    end else if (chain) begin
                        op_q  <= operator_input;
                        state <= ST_ENTER_B;
                    end
                end
                ST_ERROR: begin
                    if (k_eq) begin
                        err      <= 1'b0;
                        op_q     <= OP_NONE;
                        result_q <= '0;
                        state    <= ST_ENTER_A;
                    end
                end
                default: state <= ST_ENTER_A;
            endcase
        end
    end

endmodule
